dummy_apb_timer_array: RTL

Parametrised successor of the dummy training IP: an APB3 slave holding NUM_CH independent up-counters with compare, auto-reload and per-channel interrupt.
Instantiated under the dummy top as the first dummy block with real register-mapped behaviour.
Exercises the full PULP peripheral-integration flow: APB hookup, address decoding and interrupt routing.

---
 rtl/dummy_apb_timer_array.sv | 121 ++++++++++++
 1 files changed

// File: rtl/dummy_apb_timer_array.sv
// APB3 slave with NUM_CH independent up-counters: compare, auto-reload or one-shot stop, and a
// level interrupt per channel. Channel c sits at byte base c*0x10 (CTRL, CMP, VAL, STATUS).
module dummy_apb_timer_array #(
  parameter int NUM_CH         = 2,
  parameter int CNT_WIDTH      = 32,
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [31:0]               pwdata_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic [NUM_CH-1:0]         irq_o
);

  localparam int IDX_W = APB_ADDR_WIDTH - 4;

  logic [IDX_W-1:0]     ch_idx;
  logic [1:0]           reg_off;
  logic                 ch_ok;
  logic                 wr_en;
  logic                 rd_en;
  logic                 unused_bits;

  logic [NUM_CH-1:0]    en_a;
  logic [NUM_CH-1:0]    ar_a;
  logic [NUM_CH-1:0]    ie_a;
  logic [NUM_CH-1:0]    evt_a;
  logic [CNT_WIDTH-1:0] cmp_a [NUM_CH];
  logic [CNT_WIDTH-1:0] val_a [NUM_CH];

  // Byte lanes below the word are not decoded; write data above CNT_WIDTH is dropped.
  assign unused_bits = ^{paddr_i[1:0], pwdata_i};

  assign ch_idx    = paddr_i[APB_ADDR_WIDTH-1:4];
  assign reg_off   = paddr_i[3:2];
  assign ch_ok     = {{(32-IDX_W){1'b0}}, ch_idx} < 32'(NUM_CH);
  assign wr_en     = psel_i & penable_i & pwrite_i;
  assign rd_en     = psel_i & penable_i & ~pwrite_i;
  assign pready_o  = 1'b1;
  assign pslverr_o = psel_i & penable_i & ~ch_ok;
  assign irq_o     = evt_a & ie_a;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic                 en_q;
    logic                 ar_q;
    logic                 ie_q;
    logic                 evt_q;
    logic [CNT_WIDTH-1:0] cmp_q;
    logic [CNT_WIDTH-1:0] val_q;
    logic                 hit;
    logic                 match;

    assign hit   = wr_en & ch_ok & (ch_idx == IDX_W'(c));
    assign match = en_q & (val_q == cmp_q);

    // APB writes are placed last so they override the counter update on the same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        en_q  <= 1'b0;
        ar_q  <= 1'b0;
        ie_q  <= 1'b0;
        evt_q <= 1'b0;
        cmp_q <= '0;
        val_q <= '0;
      end else begin
        if (match) begin
          if (ar_q) val_q <= '0;
          else      en_q  <= 1'b0;
        end else if (en_q) begin
          val_q <= val_q + CNT_WIDTH'(1);
        end
        if (match)
          evt_q <= 1'b1;
        else if (hit && reg_off == 2'd3 && pwdata_i[0])
          evt_q <= 1'b0;
        if (hit) begin
          case (reg_off)
            2'd0: begin
              en_q <= pwdata_i[0];
              ar_q <= pwdata_i[1];
              ie_q <= pwdata_i[2];
            end
            2'd1:    cmp_q <= pwdata_i[CNT_WIDTH-1:0];
            2'd2:    val_q <= pwdata_i[CNT_WIDTH-1:0];
            default: ;
          endcase
        end
      end
    end

    assign en_a[c]  = en_q;
    assign ar_a[c]  = ar_q;
    assign ie_a[c]  = ie_q;
    assign evt_a[c] = evt_q;
    assign cmp_a[c] = cmp_q;
    assign val_a[c] = val_q;
  end

  always_comb begin
    prdata_o = '0;
    if (rd_en && ch_ok) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_idx == IDX_W'(i)) begin
          case (reg_off)
            2'd0:    prdata_o = {29'b0, ie_a[i], ar_a[i], en_a[i]};
            2'd1:    prdata_o = 32'(cmp_a[i]);
            2'd2:    prdata_o = 32'(val_a[i]);
            default: prdata_o = {31'b0, evt_a[i]};
          endcase
        end
      end
    end
  end

endmodule
